// File: rtl/dmem_write_buffer.sv
// Posted-store write buffer between the core data port and the system bus.
// Stores drain in order; a load waits for the buffer to empty, then issues one bus read and stalls the core until the data returns.
module dmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_be,
  input  logic        core_we,
  input  logic        core_re,
  output logic [31:0] core_rdata,
  output logic        stall,
  output logic        buf_empty,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;

  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [3:0]  mem_be   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [31:0]   core_rdata_q, core_rdata_d;

  logic full, has_data, enq, pop, rd_issue;

  always_comb begin
    full     = (count_q == FULL_CNT);
    has_data = (count_q != '0);
    enq      = core_we && !full;
    pop      = has_data && bus_gnt;
    // A load only reaches the bus once every older store has drained.
    rd_issue = (state_q == IDLE) && core_re && !core_we && !has_data;

    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (has_data) begin
      bus_req   = 1'b1;
      bus_we    = 1'b1;
      bus_addr  = mem_addr[rd_ptr_q];
      bus_wdata = mem_data[rd_ptr_q];
      bus_be    = mem_be[rd_ptr_q];
    end else if (rd_issue) begin
      bus_req  = 1'b1;
      bus_addr = core_addr;
      bus_be   = 4'hF;
    end

    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (enq && !pop)      count_d = count_q + 1'b1;
    else if (pop && !enq) count_d = count_q - 1'b1;

    state_d      = state_q;
    core_rdata_d = core_rdata_q;
    case (state_q)
      IDLE:    if (rd_issue && bus_gnt) state_d = RD_WAIT;
      RD_WAIT: if (bus_rvalid) begin
        core_rdata_d = bus_rdata;
        state_d      = RD_DONE;
      end
      RD_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall     = (core_we && full) || (core_re && !core_we && state_q != RD_DONE);
    buf_empty = !has_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      core_rdata_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      core_rdata_q <= core_rdata_d;
    end
  end

  // Storage is not reset; entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wr_ptr_q] <= core_addr;
      mem_data[wr_ptr_q] <= core_wdata;
      mem_be[wr_ptr_q]   <= core_be;
    end
  end

  assign core_rdata = core_rdata_q;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: directed scenarios then random stores/loads,
// checked against a queue of posted stores and the load protocol rules.
module tb_dmem_write_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_be;
  logic        core_we, core_re, stall, buf_empty;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  dmem_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_be(core_be),
    .core_we(core_we), .core_re(core_re), .core_rdata(core_rdata),
    .stall(stall), .buf_empty(buf_empty),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: check bus against the store queue, update the queue, advance.
  task automatic tick();
    int   sz;
    ent_t e;
    #1;
    if (q.size() > 0) begin
      chk("wr_req",   bus_req,   1);
      chk("wr_we",    bus_we,    1);
      chk("wr_addr",  bus_addr,  q[0].addr);
      chk("wr_data",  bus_wdata, q[0].data);
      chk("wr_be",    bus_be,    q[0].be);
    end else if (!core_re) begin
      chk("idle_req",   bus_req,   0);
      chk("idle_addr",  bus_addr,  0);
      chk("idle_wdata", bus_wdata, 0);
      chk("idle_be",    bus_be,    0);
    end
    chk("buf_empty", buf_empty, q.size() == 0);
    sz = q.size();
    if (sz > 0 && bus_gnt) e = q.pop_front();
    if (core_we && sz < DEPTH) q.push_back('{core_addr, core_wdata, core_be});
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit rand_gnt);
    bit done = 0;
    int n = 0;
    core_we = 1; core_re = 0; core_addr = a; core_wdata = d; core_be = be;
    while (!done && n < 64) begin
      bus_gnt = rand_gnt ? 1'($urandom % 2) : 1'b0;
      #1;
      done = (q.size() < DEPTH);
      chk("st_stall", stall, !done);
      tick();
      n++;
    end
    if (!done) chk("st_timeout", 0, 1);
    core_we = 0; bus_gnt = 0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d, input int delay,
                         input bit always_gnt, output int stall_cycles);
    bit issued = 0;
    int n = 0;
    stall_cycles = 0;
    core_re = 1; core_we = 0; core_addr = a; bus_rvalid = 0;
    while (!issued && n < 64) begin
      bus_gnt = always_gnt ? 1'b1 : 1'($urandom % 2);
      #1;
      chk("ld_stall", stall, 1);
      stall_cycles += int'(stall);
      if (q.size() == 0) begin
        chk("rd_req",   bus_req,   1);
        chk("rd_we",    bus_we,    0);
        chk("rd_addr",  bus_addr,  a);
        chk("rd_be",    bus_be,    4'hF);
        chk("rd_wdata", bus_wdata, 0);
        issued = bus_gnt;
      end
      tick();
      n++;
    end
    if (!issued) chk("rd_timeout", 0, 1);
    for (int i = 0; i < delay; i++) begin
      bus_gnt = 1'($urandom % 2);
      bus_rvalid = 0;
      #1;
      chk("wait_stall", stall, 1);
      chk("wait_req", bus_req, 0);
      stall_cycles += int'(stall);
      tick();
    end
    bus_gnt = 0; bus_rvalid = 1; bus_rdata = d;
    #1;
    chk("rv_stall", stall, 1);
    stall_cycles += int'(stall);
    tick();
    bus_rvalid = 0; bus_rdata = $urandom;
    #1;
    chk("done_stall", stall, 0);
    chk("rdata", core_rdata, d);
    tick();
    core_re = 0;
  endtask

  task automatic drain(input int n);
    bus_gnt = 1;
    repeat (n) tick();
    bus_gnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int sc;
    logic [31:0] keep, rd;
    rst = 1; core_addr = 0; core_wdata = 0; core_be = 0; core_we = 0; core_re = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_empty", buf_empty, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_rdata", core_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // three posted stores, no grant
    do_store(32'h1000, 32'h11, 4'hF, 0);
    do_store(32'h1004, 32'h22, 4'hF, 0);
    do_store(32'h1008, 32'h33, 4'hF, 0);
    #1;
    chk("t1_req", bus_req, 1);
    chk("t1_addr", bus_addr, 32'h1000);
    drain(3);
    chk("t1_empty", buf_empty, 1);

    // full buffer stalls a fifth store until one gnt frees a slot
    for (int i = 0; i < 4; i++) do_store(32'h1100 + 4*i, 32'hA0 + i, 4'hF, 0);
    core_we = 1; core_addr = 32'h1010; core_wdata = 32'h55AA; core_be = 4'h3;
    bus_gnt = 0; #1; chk("full_stall0", stall, 1); tick();
    bus_gnt = 1; #1; chk("full_stall1", stall, 1); tick();
    bus_gnt = 0; #1; chk("full_stall2", stall, 0); tick();
    core_we = 0;
    chk("full_cnt4", q.size(), 4);
    drain(3);
    chk("full_left1", buf_empty, 0);
    drain(1);
    chk("full_empty", buf_empty, 1);

    // load behind two pending stores
    do_store(32'h2000, 32'h1, 4'h1, 0);
    do_store(32'h2004, 32'h2, 4'h2, 0);
    do_load(32'h1004, 32'hDEADBEEF, 0, 1, sc);
    chk("ld2_stalls", sc, 4);

    // spurious rvalid and gnt in IDLE
    keep = core_rdata;
    bus_rvalid = 1; bus_rdata = 32'h55; bus_gnt = 1;
    tick();
    bus_rvalid = 0; bus_gnt = 0;
    #1;
    chk("spur_rdata", core_rdata, keep);
    chk("spur_empty", buf_empty, 1);
    chk("spur_stall", stall, 0);

    // empty-buffer load, gnt at issue, rvalid 3 cycles later
    do_load(32'h3000, 32'hCAFEF00D, 2, 1, sc);
    chk("ld_empty_stalls", sc, 4);
    do_load(32'h3004, 32'h12345678, 0, 1, sc);
    chk("ld_best_stalls", sc, 2);

    // reset mid-drain
    do_store(32'h4000, 32'h7, 4'hF, 0);
    do_store(32'h4004, 32'h8, 4'hF, 0);
    do_store(32'h4008, 32'h9, 4'hF, 0);
    bus_gnt = 1; rst = 1;
    #1;
    chk("mrst_req", bus_req, 0);
    chk("mrst_empty", buf_empty, 1);
    chk("mrst_rdata", core_rdata, 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    repeat (3) tick();
    bus_gnt = 0;

    // random mix
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 3 != 0)
        do_store({$urandom_range(0, 255), 2'b00} + 32'h8000, $urandom, 4'($urandom), 1);
      else begin
        rd = $urandom;
        do_load({$urandom_range(0, 255), 2'b00} + 32'h9000, rd, $urandom_range(0, 3), 0, sc);
      end
    end
    drain(DEPTH);
    chk("rand_empty", buf_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
